// File: rtl/i2s_frame_ctrl.sv
// I2S frame controller: generates word select and frame strobe, buffers received pairs toward
// a processing block, and swaps processed pairs onto the transmit outputs at frame boundaries.
module i2s_frame_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             sclk,
  input  logic             rst,
  input  logic             en_i,
  output logic             ws_o,
  output logic             frame_o,
  input  logic [WIDTH-1:0] rx_left_i,
  input  logic [WIDTH-1:0] rx_right_i,
  input  logic             rx_pkt_i,
  output logic [WIDTH-1:0] dsp_left_o,
  output logic [WIDTH-1:0] dsp_right_o,
  output logic             dsp_valid_o,
  input  logic             dsp_ready_i,
  input  logic [WIDTH-1:0] dsp_left_i,
  input  logic [WIDTH-1:0] dsp_right_i,
  input  logic             dsp_valid_i,
  output logic [WIDTH-1:0] tx_left_o,
  output logic [WIDTH-1:0] tx_right_o,
  output logic [7:0]       ovf_cnt_o,
  output logic [7:0]       udr_cnt_o,
  output logic             busy_o
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic              ws_q, ws_d;
  logic [WIDTH-1:0]  dsp_l_q, dsp_l_d, dsp_r_q, dsp_r_d;
  logic              dsp_valid_q, dsp_valid_d;
  logic [WIDTH-1:0]  pend_l_q, pend_l_d, pend_r_q, pend_r_d;
  logic              pend_q, pend_d;
  logic [WIDTH-1:0]  tx_l_q, tx_l_d, tx_r_q, tx_r_d;
  logic [7:0]        ovf_q, ovf_d, udr_q, udr_d;

  logic last_bit, frame, rx_accept, dsp_hs;

  assign last_bit  = (bit_cnt_q == CntW'(WIDTH - 1));
  assign frame     = (state_q != StIdle) && ws_q && last_bit;
  assign rx_accept = rx_pkt_i && (state_q != StIdle);
  assign dsp_hs    = dsp_valid_q && dsp_ready_i;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    ws_d      = ws_q;
    case (state_q)
      StIdle: begin
        bit_cnt_d = '0;
        ws_d      = 1'b0;
        if (en_i) state_d = StRun;
      end
      StRun, StDrain: begin
        if (last_bit) begin
          bit_cnt_d = '0;
          ws_d      = ~ws_q;
        end else begin
          bit_cnt_d = bit_cnt_q + CntW'(1);
        end
        // Once draining, en_i is ignored until the frame completes.
        if (state_q == StRun && !en_i) begin
          state_d = StDrain;
        end else if (state_q == StDrain && frame) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    dsp_l_d     = dsp_l_q;
    dsp_r_d     = dsp_r_q;
    dsp_valid_d = dsp_valid_q;
    ovf_d       = ovf_q;
    if (rx_accept) begin
      dsp_l_d     = rx_left_i;
      dsp_r_d     = rx_right_i;
      dsp_valid_d = 1'b1;
      if (dsp_valid_q && !dsp_ready_i && ovf_q != 8'hFF) ovf_d = ovf_q + 8'd1;
    end else if (dsp_hs) begin
      dsp_valid_d = 1'b0;
    end
  end

  always_comb begin
    pend_l_d = pend_l_q;
    pend_r_d = pend_r_q;
    pend_d   = pend_q;
    tx_l_d   = tx_l_q;
    tx_r_d   = tx_r_q;
    udr_d    = udr_q;
    if (frame) begin
      // A pair arriving on the boundary itself bypasses the pending register.
      if (dsp_valid_i) begin
        tx_l_d = dsp_left_i;
        tx_r_d = dsp_right_i;
      end else if (pend_q) begin
        tx_l_d = pend_l_q;
        tx_r_d = pend_r_q;
      end else if (udr_q != 8'hFF) begin
        udr_d = udr_q + 8'd1;
      end
      pend_d = 1'b0;
    end else if (dsp_valid_i) begin
      pend_l_d = dsp_left_i;
      pend_r_d = dsp_right_i;
      pend_d   = 1'b1;
    end
  end

  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      ws_q        <= 1'b0;
      dsp_l_q     <= '0;
      dsp_r_q     <= '0;
      dsp_valid_q <= 1'b0;
      pend_l_q    <= '0;
      pend_r_q    <= '0;
      pend_q      <= 1'b0;
      tx_l_q      <= '0;
      tx_r_q      <= '0;
      ovf_q       <= '0;
      udr_q       <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      ws_q        <= ws_d;
      dsp_l_q     <= dsp_l_d;
      dsp_r_q     <= dsp_r_d;
      dsp_valid_q <= dsp_valid_d;
      pend_l_q    <= pend_l_d;
      pend_r_q    <= pend_r_d;
      pend_q      <= pend_d;
      tx_l_q      <= tx_l_d;
      tx_r_q      <= tx_r_d;
      ovf_q       <= ovf_d;
      udr_q       <= udr_d;
    end
  end

  assign ws_o        = ws_q;
  assign frame_o     = frame;
  assign dsp_left_o  = dsp_l_q;
  assign dsp_right_o = dsp_r_q;
  assign dsp_valid_o = dsp_valid_q;
  assign tx_left_o   = tx_l_q;
  assign tx_right_o  = tx_r_q;
  assign ovf_cnt_o   = ovf_q;
  assign udr_cnt_o   = udr_q;
  assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_i2s_frame_ctrl.sv
// Scoreboard bench for i2s_frame_ctrl: a frame-position model predicts per-cycle status,
// handshaked dsp pairs and per-frame tx pairs; a monitor compares them as the DUT presents them.
module tb_i2s_frame_ctrl;

  localparam int W = 16;

  logic         sclk = 1'b0;
  logic         rst;
  logic         en_i, rx_pkt_i, dsp_ready_i, dsp_valid_i;
  logic [W-1:0] rx_left_i, rx_right_i, dsp_left_i, dsp_right_i;
  logic         ws_o, frame_o, dsp_valid_o, busy_o;
  logic [W-1:0] dsp_left_o, dsp_right_o, tx_left_o, tx_right_o;
  logic [7:0]   ovf_cnt_o, udr_cnt_o;

  i2s_frame_ctrl #(.WIDTH(W)) dut (
    .sclk        (sclk),
    .rst         (rst),
    .en_i        (en_i),
    .ws_o        (ws_o),
    .frame_o     (frame_o),
    .rx_left_i   (rx_left_i),
    .rx_right_i  (rx_right_i),
    .rx_pkt_i    (rx_pkt_i),
    .dsp_left_o  (dsp_left_o),
    .dsp_right_o (dsp_right_o),
    .dsp_valid_o (dsp_valid_o),
    .dsp_ready_i (dsp_ready_i),
    .dsp_left_i  (dsp_left_i),
    .dsp_right_i (dsp_right_i),
    .dsp_valid_i (dsp_valid_i),
    .tx_left_o   (tx_left_o),
    .tx_right_o  (tx_right_o),
    .ovf_cnt_o   (ovf_cnt_o),
    .udr_cnt_o   (udr_cnt_o),
    .busy_o      (busy_o)
  );

  always #5 sclk = ~sclk;

  typedef struct {
    logic       ws;
    logic       frame;
    logic       busy;
    logic       dvalid;
    logic [7:0] ovf;
    logic [7:0] udr;
  } cyc_t;

  cyc_t        cyc_q[$];
  logic [31:0] dsp_q[$];
  logic [31:0] tx_q[$];

  int n_chk = 0;
  int n_fail = 0;
  logic mon_en = 1'b0;
  logic tx_chk_pend = 1'b0;

  // Reference model: mode 0 idle, 1 run, 2 drain; pos is the position within a 2*W frame.
  int          m_mode, m_pos, m_ovf, m_udr;
  logic        m_off, m_pend;
  logic [31:0] m_pend_data, m_tx;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_pos = 0; m_ovf = 0; m_udr = 0;
    m_off = 1'b0; m_pend = 1'b0; m_pend_data = '0; m_tx = '0;
    cyc_q.delete(); dsp_q.delete(); tx_q.delete();
    tx_chk_pend = 1'b0;
  endtask

  task automatic step(input logic en, input logic rx, input logic [W-1:0] rl, input logic [W-1:0] rr,
                      input logic rdy, input logic dv, input logic [W-1:0] dl,
                      input logic [W-1:0] dr);
    cyc_t e;
    logic frm;
    @(posedge sclk);
    #1;
    en_i = en; rx_pkt_i = rx; rx_left_i = rl; rx_right_i = rr;
    dsp_ready_i = rdy; dsp_valid_i = dv; dsp_left_i = dl; dsp_right_i = dr;
    frm      = (m_mode != 0) && (m_pos == 2 * W - 1);
    e.ws     = (m_mode != 0) && (m_pos >= W);
    e.frame  = frm;
    e.busy   = (m_mode != 0);
    e.dvalid = m_off;
    e.ovf    = 8'(m_ovf);
    e.udr    = 8'(m_udr);
    cyc_q.push_back(e);
    if (rx && m_mode != 0) begin
      if (m_off && !rdy) begin
        void'(dsp_q.pop_back());
        if (m_ovf < 255) m_ovf++;
      end
      dsp_q.push_back({rl, rr});
      m_off = 1'b1;
    end else if (m_off && rdy) begin
      m_off = 1'b0;
    end
    if (frm) begin
      if (dv) m_tx = {dl, dr};
      else if (m_pend) m_tx = m_pend_data;
      else if (m_udr < 255) m_udr++;
      m_pend = 1'b0;
      tx_q.push_back(m_tx);
    end else if (dv) begin
      m_pend = 1'b1;
      m_pend_data = {dl, dr};
    end
    if (m_mode == 0) begin
      if (en) m_mode = 1;
    end else begin
      if (m_mode == 1 && !en) m_mode = 2;
      else if (m_mode == 2 && frm) m_mode = 0;
      m_pos = (m_pos + 1) % (2 * W);
    end
    mon_en = 1'b1;
  endtask

  task automatic idle_step(input logic en);
    step(en, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic rand_step(input int p_rx, input int p_rdy, input int p_dv, input int p_en);
    step(($urandom_range(0, 999) < p_en), ($urandom_range(0, 99) < p_rx), W'($urandom),
         W'($urandom), ($urandom_range(0, 99) < p_rdy), ($urandom_range(0, 999) < p_dv),
         W'($urandom), W'($urandom));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ws"}, 32'(ws_o), 0);
    chk({tag, "_frame"}, 32'(frame_o), 0);
    chk({tag, "_busy"}, 32'(busy_o), 0);
    chk({tag, "_dvalid"}, 32'(dsp_valid_o), 0);
    chk({tag, "_dsp"}, {dsp_left_o, dsp_right_o}, 0);
    chk({tag, "_tx"}, {tx_left_o, tx_right_o}, 0);
    chk({tag, "_cnt"}, {16'h0, ovf_cnt_o, udr_cnt_o}, 0);
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard queues.
  cyc_t mon_e;
  initial begin
    forever begin
      @(negedge sclk);
      if (mon_en) begin
        if (cyc_q.size() == 0) begin
          chk("cyc_queue_empty", 32'd1, 32'd0);
        end else begin
          mon_e = cyc_q.pop_front();
          chk("ws", 32'(ws_o), 32'(mon_e.ws));
          chk("frame", 32'(frame_o), 32'(mon_e.frame));
          chk("busy", 32'(busy_o), 32'(mon_e.busy));
          chk("dsp_valid", 32'(dsp_valid_o), 32'(mon_e.dvalid));
          chk("ovf_cnt", 32'(ovf_cnt_o), 32'(mon_e.ovf));
          chk("udr_cnt", 32'(udr_cnt_o), 32'(mon_e.udr));
        end
        if (tx_chk_pend) begin
          tx_chk_pend = 1'b0;
          if (tx_q.size() == 0) chk("tx_queue_empty", 32'd1, 32'd0);
          else chk("tx_pair", {tx_left_o, tx_right_o}, tx_q.pop_front());
        end
        if (frame_o) tx_chk_pend = 1'b1;
        if (dsp_valid_o && dsp_ready_i) begin
          if (dsp_q.size() == 0) chk("dsp_queue_empty", 32'd1, 32'd0);
          else chk("dsp_pair", {dsp_left_o, dsp_right_o}, dsp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic walk_to(input int mode, input int pos, input string nm);
    int k;
    k = 0;
    while (!(m_mode == mode && m_pos == pos) && k < 200) begin
      idle_step(1'b1);
      k++;
    end
    chk({nm, "_reached"}, 32'(k < 200), 32'd1);
  endtask

  initial begin
    en_i = 0; rx_pkt_i = 0; dsp_ready_i = 0; dsp_valid_i = 0;
    rx_left_i = '0; rx_right_i = '0; dsp_left_i = '0; dsp_right_i = '0;
    rst = 1'b0;
    model_reset();
    #1;
    check_all_zero("reset");
    #22;
    rst = 1'b1;

    // Overwrite while blocked: second pair replaces first, one overrun.
    repeat (3) idle_step(1'b1);
    step(1'b1, 1'b1, 16'h1234, 16'hABCD, 1'b0, 1'b0, '0, '0);
    step(1'b1, 1'b1, 16'h5555, 16'hAAAA, 1'b0, 1'b0, '0, '0);
    idle_step(1'b1);
    @(negedge sclk);
    chk("ovr_pair", {dsp_left_o, dsp_right_o}, 32'h5555AAAA);
    step(1'b1, 1'b0, '0, '0, 1'b1, 1'b0, '0, '0);

    // Mid-frame processed pair, then a frame without one.
    walk_to(1, 7, "mid_frame");
    step(1'b1, 1'b0, '0, '0, 1'b0, 1'b1, 16'h0F0F, 16'hF0F0);
    repeat (3 * 2 * W) idle_step(1'b1);

    // Pair on the boundary, and rx coincident with an accepting handshake.
    walk_to(1, 2 * W - 1, "boundary");
    step(1'b1, 1'b1, 16'h1111, 16'h2222, 1'b0, 1'b1, 16'hBEEF, 16'hCAFE);
    step(1'b1, 1'b1, 16'h3333, 16'h4444, 1'b1, 1'b0, '0, '0);
    step(1'b1, 1'b0, '0, '0, 1'b1, 1'b0, '0, '0);
    repeat (2 * W) idle_step(1'b1);

    // Drop en on left bit 3, keep it high during drain, then restart from idle.
    walk_to(1, 3, "drain_start");
    idle_step(1'b0);
    repeat (3 * W) idle_step(1'b1);

    repeat (4000) rand_step(30, 50, 25, 997);

    repeat (300) step(1'b1, 1'b1, W'($urandom), W'($urandom), 1'b0, 1'b0, '0, '0);
    repeat (260 * 2 * W) idle_step(1'b1);

    // Asynchronous reset in the middle of a frame with a pair offered.
    walk_to(1, 20, "rst_point");
    step(1'b1, 1'b1, 16'h7777, 16'h8888, 1'b0, 1'b1, 16'h9999, 16'h6666);
    @(posedge sclk);
    #3;
    mon_en = 1'b0;
    rst = 1'b0;
    #1;
    check_all_zero("midrst");
    en_i = 0; rx_pkt_i = 0; dsp_valid_i = 0; dsp_ready_i = 0;
    repeat (2) @(posedge sclk);
    #1;
    rst = 1'b1;
    model_reset();

    repeat (1500) rand_step(40, 60, 30, 998);
    step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    @(negedge sclk);
    chk("dsp_leftover", 32'(dsp_q.size()), 32'(m_off));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
